// File: rtl/cdc_toggle_handshake_receiver.sv
// Destination side of a toggle-based CDC handshake: capture a word on each request
// toggle, hold it for the local consumer, and return an ack toggle once it is consumed.
module cdc_toggle_handshake_receiver #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   dest_domain_clock,
  input  logic                   dest_domain_reset_n,
  input  logic                   req_toggle_synchronised,
  input  logic [DATA_WIDTH-1:0]  data_in_foreign,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   data_valid,
  input  logic                   data_ready,
  output logic                   ack_toggle,
  output logic                   protocol_error,
  output logic [COUNT_WIDTH-1:0] transfer_count
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t state;
  logic   last_req;
  logic   req_edge;

  assign req_edge = (req_toggle_synchronised != last_req);

  always_ff @(posedge dest_domain_clock or negedge dest_domain_reset_n) begin
    if (!dest_domain_reset_n) begin
      state          <= IDLE;
      last_req       <= 1'b0;
      data_out       <= '0;
      data_valid     <= 1'b0;
      ack_toggle     <= 1'b0;
      protocol_error <= 1'b0;
      transfer_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_edge) begin
            data_out   <= data_in_foreign;
            last_req   <= req_toggle_synchronised;
            data_valid <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          // An edge on the completing cycle is left pending and picked up from IDLE next cycle.
          if (data_ready) begin
            data_valid     <= 1'b0;
            ack_toggle     <= ~ack_toggle;
            transfer_count <= transfer_count + 1'b1;
            state          <= IDLE;
          end else if (req_edge) begin
            protocol_error <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
